sr_latch_writer: RTL

//   Write-side controller for an enable-gated SR latch (s, r, c -> Q). Accepts
//   one-bit write requests over a valid/ready handshake and produces a safe
//   s/r/c pulse sequence: s/r are stable before c rises and held after c falls,
//   and s=r=1 is never driven. After each write it reads back the latch Q and

---
 rtl/sr_latch_writer_if.sv | 24 ++
 rtl/sr_latch_writer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sr_latch_writer_if.sv
// Write-request handshake and latch-side signals for sr_latch_writer.
// slave is the controller's view; master is the client/latch side.
interface sr_latch_writer_if;
   logic req_valid;
   logic req_data;
   logic req_ready;
   logic s;
   logic r;
   logic c;
   logic q_fb;
   logic done;
   logic err;
   logic busy;

   modport slave (
      input  req_valid, req_data, q_fb,
      output req_ready, s, r, c, done, err, busy
   );

   modport master (
      output req_valid, req_data, q_fb,
      input  req_ready, s, r, c, done, err, busy
   );
endinterface

// File: rtl/sr_latch_writer.sv
// Write-side controller for an enable-gated SR latch: sequences s/r setup,
// c strobe and hold, then reads Q back and reports a mismatch with done.
module sr_latch_writer #(
   parameter int unsigned SETUP_W  = 1,
   parameter int unsigned PULSE_W  = 2,
   parameter int unsigned HOLD_W   = 1,
   parameter int unsigned SETTLE_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   sr_latch_writer_if.slave bus
);

   localparam int unsigned MAX_AB = (SETUP_W > PULSE_W) ? SETUP_W : PULSE_W;
   localparam int unsigned MAX_CD = (HOLD_W > SETTLE_W) ? HOLD_W : SETTLE_W;
   localparam int unsigned MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t SETUP_LD  = cnt_t'(SETUP_W - 1);
   localparam cnt_t PULSE_LD  = cnt_t'(PULSE_W - 1);
   localparam cnt_t HOLD_LD   = cnt_t'(HOLD_W - 1);
   localparam cnt_t SETTLE_LD = cnt_t'((SETTLE_W > 0) ? SETTLE_W - 1 : 0);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SETTLE, CHECK} state_t;

   state_t state_q, state_d;
   cnt_t   cnt_q, cnt_d;
   logic   data_q, data_d;
   logic   s_q, s_d, r_q, r_d, c_q, c_d;
   logic   done_q, done_d, err_q, err_d, busy_q, busy_d;
   logic   drive_sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         c_q     <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         s_q     <= s_d;
         r_q     <= r_d;
         c_q     <= c_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               data_d  = bus.req_data;
               state_d = SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = (SETTLE_W == 0) ? CHECK : SETTLE;
               cnt_d   = SETTLE_LD;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode the next state so they are registered alongside it.
   always_comb begin
      drive_sr = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      s_d      = drive_sr & data_d;
      r_d      = drive_sr & ~data_d;
      c_d      = (state_d == STROBE);
      busy_d   = (state_d != IDLE);
      done_d   = (state_q == CHECK);
      err_d    = done_d & (bus.q_fb != data_q);
   end

   assign bus.req_ready = (state_q == IDLE) & ~reset;
   assign bus.s         = s_q;
   assign bus.r         = r_q;
   assign bus.c         = c_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;

endmodule
